// File: rtl/quad_step_driver_pkg.sv
// Shared types and constants for the quadrature step driver and its input filters.
package quad_step_driver_pkg;

  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefFiltLen    = 4;
  localparam logic [3:0]  DefPreset     = 4'd0;

  typedef enum logic {
    StSeed,
    StTrack
  } qsd_state_e;

  // Successor of {A,B} when the shaft turns forward: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] gray_fwd(input logic [1:0] ab);
    logic [1:0] nxt;
    unique case (ab)
      2'b00: nxt = 2'b01;
      2'b01: nxt = 2'b11;
      2'b11: nxt = 2'b10;
      2'b10: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] gray_rev(input logic [1:0] ab);
    logic [1:0] nxt;
    unique case (ab)
      2'b00: nxt = 2'b10;
      2'b10: nxt = 2'b11;
      2'b11: nxt = 2'b01;
      2'b01: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_step_driver_input_filter.sv
// Synchronizer plus debounce for one asynchronous encoder pin.
module quad_input_filter
  import quad_step_driver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned FILT_LEN    = DefFiltLen
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic busy_o
);

  localparam logic [3:0] FiltLast = 4'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
    cnt_d   = 4'd0;
    level_d = level_q;
    if (sample != level_q) begin
      if (cnt_q == FiltLast) begin
        level_d = sample;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= 4'd0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  // Busy while any value still in flight could move the filtered level.
  assign busy_o  = (sync_q != {SYNC_STAGES{level_q}});

endmodule

// File: rtl/quad_step_driver.sv
// Turns filtered quadrature A/B/index levels into registered load/inc/dec/error pulses.
module quad_step_driver
  import quad_step_driver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned FILT_LEN    = DefFiltLen,
  parameter logic [3:0]  PRESET      = DefPreset
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       index,
  output logic       load_en,
  output logic       inc_en,
  output logic       dec_en,
  output logic [3:0] din,
  output logic       step_err,
  output logic       err_sticky
);

  localparam logic [3:0] SeedLast = 4'(FILT_LEN - 1);

  logic a_lvl, b_lvl, idx_lvl;
  logic a_busy, b_busy, idx_busy;

  quad_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_a (
    .clk_i  (clk),
    .rst_ni (reset),
    .pin_i  (quad_a),
    .level_o(a_lvl),
    .busy_o (a_busy)
  );

  quad_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_b (
    .clk_i  (clk),
    .rst_ni (reset),
    .pin_i  (quad_b),
    .level_o(b_lvl),
    .busy_o (b_busy)
  );

  quad_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_idx (
    .clk_i  (clk),
    .rst_ni (reset),
    .pin_i  (index),
    .level_o(idx_lvl),
    .busy_o (idx_busy)
  );

  qsd_state_e state_q, state_d;
  logic [3:0] seed_cnt_q, seed_cnt_d;
  logic [1:0] prev_ab_q, prev_ab_d;
  logic       idx_prev_q, idx_prev_d;
  logic       load_en_q, load_en_d;
  logic       inc_en_q, inc_en_d;
  logic       dec_en_q, dec_en_d;
  logic       step_err_q, step_err_d;
  logic       err_sticky_q, err_sticky_d;

  logic [1:0] cur_ab;
  logic       any_busy;
  logic       moved, is_fwd, is_rev, is_illegal, idx_rise;

  assign cur_ab     = {a_lvl, b_lvl};
  assign any_busy   = a_busy | b_busy | idx_busy;
  assign moved      = (cur_ab != prev_ab_q);
  assign is_fwd     = moved && (cur_ab == gray_fwd(prev_ab_q));
  assign is_rev     = moved && (cur_ab == gray_rev(prev_ab_q));
  assign is_illegal = moved && !is_fwd && !is_rev;
  assign idx_rise   = idx_lvl & ~idx_prev_q;

  always_comb begin
    state_d      = state_q;
    seed_cnt_d   = seed_cnt_q;
    prev_ab_d    = prev_ab_q;
    idx_prev_d   = idx_prev_q;
    load_en_d    = 1'b0;
    inc_en_d     = 1'b0;
    dec_en_d     = 1'b0;
    step_err_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    unique case (state_q)
      StSeed: begin
        // Seed only once every pin has been quiet long enough that its level is final.
        if (any_busy) begin
          seed_cnt_d = 4'd0;
        end else if (seed_cnt_q == SeedLast) begin
          state_d    = StTrack;
          seed_cnt_d = 4'd0;
          prev_ab_d  = cur_ab;
          idx_prev_d = idx_lvl;
        end else begin
          seed_cnt_d = seed_cnt_q + 4'd1;
        end
      end
      StTrack: begin
        prev_ab_d    = cur_ab;
        idx_prev_d   = idx_lvl;
        // A concurrent index load wins; an illegal step is still flagged.
        load_en_d    = idx_rise;
        inc_en_d     = is_fwd & ~idx_rise;
        dec_en_d     = is_rev & ~idx_rise;
        step_err_d   = is_illegal;
        err_sticky_d = err_sticky_q | is_illegal;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StSeed;
      seed_cnt_q   <= 4'd0;
      prev_ab_q    <= 2'b00;
      idx_prev_q   <= 1'b0;
      load_en_q    <= 1'b0;
      inc_en_q     <= 1'b0;
      dec_en_q     <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_cnt_q   <= seed_cnt_d;
      prev_ab_q    <= prev_ab_d;
      idx_prev_q   <= idx_prev_d;
      load_en_q    <= load_en_d;
      inc_en_q     <= inc_en_d;
      dec_en_q     <= dec_en_d;
      step_err_q   <= step_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign load_en    = load_en_q;
  assign inc_en     = inc_en_q;
  assign dec_en     = dec_en_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
  assign din        = PRESET;

endmodule

// File: tb/tb_quad_step_driver.sv
// Directed bench for quad_step_driver: reset/seed, steps, glitch, errors, index, collisions.
module tb_quad_step_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       index = 1'b0;
  logic       load_en, inc_en, dec_en, step_err, err_sticky;
  logic [3:0] din;
  logic       load_en_a, inc_en_a, dec_en_a, step_err_a, err_sticky_a;
  logic [3:0] din_a;

  int checks = 0;
  int errors = 0;

  // Pulse tallies from the most recent watch window; t_* is the first edge seen (1-based).
  int w_load, w_inc, w_dec, w_err, w_multi;
  int t_load, t_inc, t_dec, t_err;
  int w_load_a, w_step_a, w_err_a;

  always #5 clk = ~clk;

  quad_step_driver dut (
    .clk       (clk),
    .reset     (reset),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .index     (index),
    .load_en   (load_en),
    .inc_en    (inc_en),
    .dec_en    (dec_en),
    .din       (din),
    .step_err  (step_err),
    .err_sticky(err_sticky)
  );

  quad_step_driver #(
    .PRESET(4'hA)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .index     (index),
    .load_en   (load_en_a),
    .inc_en    (inc_en_a),
    .dec_en    (dec_en_a),
    .din       (din_a),
    .step_err  (step_err_a),
    .err_sticky(err_sticky_a)
  );

  task automatic pins(input logic a, input logic b, input logic idx);
    quad_a = a;
    quad_b = b;
    index  = idx;
  endtask

  // Called on a falling edge; samples the outputs on each of the next `cycles` falling edges.
  task automatic watch(input int cycles);
    w_load = 0; w_inc = 0; w_dec = 0; w_err = 0; w_multi = 0;
    t_load = -1; t_inc = -1; t_dec = -1; t_err = -1;
    w_load_a = 0; w_step_a = 0; w_err_a = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (load_en)  begin w_load++; if (t_load < 0) t_load = i; end
      if (inc_en)   begin w_inc++;  if (t_inc < 0)  t_inc = i;  end
      if (dec_en)   begin w_dec++;  if (t_dec < 0)  t_dec = i;  end
      if (step_err) begin w_err++;  if (t_err < 0)  t_err = i;  end
      if (int'(load_en) + int'(inc_en) + int'(dec_en) > 1) w_multi++;
      if (load_en_a) w_load_a++;
      if (inc_en_a || dec_en_a) w_step_a++;
      if (step_err_a) w_err_a++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pins(1'b1, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if ({load_en, inc_en, dec_en, step_err, err_sticky} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {load_en, inc_en, dec_en, step_err, err_sticky});
    end
    checks++;
    if (din !== 4'h0 || din_a !== 4'hA) begin
      errors++;
      $display("FAIL reset_din: got %h/%h want 0/a", din, din_a);
    end
    reset = 1'b1;
    watch(20);
    checks++;
    if (w_load + w_inc + w_dec + w_err != 0) begin
      errors++;
      $display("FAIL seed_quiet: got %0d pulses want 0", w_load + w_inc + w_dec + w_err);
    end
    pins(1'b1, 1'b1, 1'b0);
    watch(10);
    checks++;
    if (w_load + w_inc + w_dec + w_err != 0) begin
      errors++;
      $display("FAIL index_fall: got %0d pulses want 0", w_load + w_inc + w_dec + w_err);
    end
    // A forward 11->10 step proves the seed captured {1,1}.
    pins(1'b1, 1'b0, 1'b0);
    watch(10);
    checks++;
    if (w_inc != 1 || t_inc != 7 || w_err != 0) begin
      errors++;
      $display("FAIL seed_prev_11: got inc=%0d at %0d err=%0d want inc=1 at 7 err=0",
               w_inc, t_inc, w_err);
    end
    pins(1'b0, 1'b0, 1'b0);
    watch(10);
    checks++;
    if (w_inc != 1 || w_dec != 0) begin
      errors++;
      $display("FAIL step_10_00: got inc=%0d dec=%0d want 1/0", w_inc, w_dec);
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      pins(seq[i][1], seq[i][0], 1'b0);
      watch(10);
      checks++;
      if (w_inc != 1 || t_inc != 7 || w_dec != 0) begin
        errors++;
        $display("FAIL forward_%0d: got inc=%0d at %0d dec=%0d want inc=1 at 7 dec=0",
                 i, w_inc, t_inc, w_dec);
      end
    end
  endtask

  task automatic test_reverse_glitch();
    pins(1'b1, 1'b0, 1'b0);
    watch(10);
    checks++;
    if (w_dec != 1 || t_dec != 7 || w_inc != 0) begin
      errors++;
      $display("FAIL reverse_00_10: got dec=%0d at %0d inc=%0d want dec=1 at 7 inc=0",
               w_dec, t_dec, w_inc);
    end
    pins(1'b0, 1'b0, 1'b0);
    watch(3);
    pins(1'b1, 1'b0, 1'b0);
    watch(15);
    checks++;
    if (w_load + w_inc + w_dec + w_err != 0) begin
      errors++;
      $display("FAIL glitch_3cyc: got %0d pulses want 0", w_load + w_inc + w_dec + w_err);
    end
  endtask

  task automatic test_illegal();
    pins(1'b0, 1'b0, 1'b0);
    watch(10);
    pins(1'b0, 1'b1, 1'b0);
    watch(10);
    checks++;
    if (err_sticky !== 1'b0 || w_inc != 1) begin
      errors++;
      $display("FAIL pre_illegal: got sticky=%b inc=%0d want 0/1", err_sticky, w_inc);
    end
    pins(1'b1, 1'b0, 1'b0);
    watch(10);
    checks++;
    if (w_err != 1 || t_err != 7 || w_inc != 0 || w_dec != 0) begin
      errors++;
      $display("FAIL illegal_01_10: got err=%0d at %0d inc=%0d dec=%0d want 1 at 7, 0, 0",
               w_err, t_err, w_inc, w_dec);
    end
    checks++;
    if (err_sticky !== 1'b1 || err_sticky_a !== 1'b1 || w_err_a != 1) begin
      errors++;
      $display("FAIL sticky_set: got %b/%b errs_a=%0d want 1/1/1", err_sticky, err_sticky_a,
               w_err_a);
    end
    pins(1'b1, 1'b1, 1'b0);
    watch(10);
    checks++;
    if (w_dec != 1 || w_inc != 0 || w_err != 0 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL after_illegal_10_11: got dec=%0d inc=%0d err=%0d sticky=%b want 1/0/0/1",
               w_dec, w_inc, w_err, err_sticky);
    end
  endtask

  task automatic test_index();
    pins(1'b1, 1'b1, 1'b1);
    watch(20);
    checks++;
    if (w_load != 1 || t_load != 7 || w_inc + w_dec != 0) begin
      errors++;
      $display("FAIL index_load: got load=%0d at %0d steps=%0d want load=1 at 7 steps=0",
               w_load, t_load, w_inc + w_dec);
    end
    checks++;
    if (din !== 4'h0 || din_a !== 4'hA || w_load_a != 1 || w_step_a != 0) begin
      errors++;
      $display("FAIL index_din: got din=%h din_a=%h load_a=%0d steps_a=%0d want 0/a/1/0",
               din, din_a, w_load_a, w_step_a);
    end
    pins(1'b1, 1'b1, 1'b0);
    watch(10);
    checks++;
    if (w_load != 0) begin
      errors++;
      $display("FAIL index_release: got load=%0d want 0", w_load);
    end
  endtask

  task automatic test_collision();
    pins(1'b0, 1'b1, 1'b0);
    watch(10);
    checks++;
    if (w_dec != 1) begin
      errors++;
      $display("FAIL coll_setup_11_01: got dec=%0d want 1", w_dec);
    end
    // A rises (forward 01->11) on the same cycle as index.
    pins(1'b1, 1'b1, 1'b1);
    watch(12);
    checks++;
    if (w_load != 1 || t_load != 7 || w_inc != 0 || w_dec != 0 || w_multi != 0) begin
      errors++;
      $display("FAIL coll_load_prio: got load=%0d at %0d inc=%0d dec=%0d multi=%0d want 1 at 7",
               w_load, t_load, w_inc, w_dec, w_multi);
    end
    pins(1'b1, 1'b1, 1'b0);
    watch(10);
    pins(1'b0, 1'b0, 1'b1);
    watch(12);
    checks++;
    if (w_load != 1 || w_err != 1 || t_err != t_load || w_inc + w_dec != 0) begin
      errors++;
      $display("FAIL coll_illegal: got load=%0d err=%0d at %0d/%0d steps=%0d want 1/1 same cycle",
               w_load, w_err, t_load, t_err, w_inc + w_dec);
    end
    pins(1'b0, 1'b0, 1'b0);
    watch(10);
  endtask

  task automatic test_reset_midop();
    pins(1'b0, 1'b1, 1'b0);
    watch(4);
    reset = 1'b0;
    watch(2);
    checks++;
    if (err_sticky !== 1'b0 || w_load + w_inc + w_dec + w_err != 0) begin
      errors++;
      $display("FAIL midop_reset: got sticky=%b pulses=%0d want 0/0", err_sticky,
               w_load + w_inc + w_dec + w_err);
    end
    reset = 1'b1;
    watch(30);
    checks++;
    if (w_load + w_inc + w_dec + w_err != 0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL midop_reseed: got pulses=%0d sticky=%b want 0/0",
               w_load + w_inc + w_dec + w_err, err_sticky);
    end
    pins(1'b1, 1'b1, 1'b0);
    watch(10);
    checks++;
    if (w_inc != 1 || t_inc != 7 || w_dec + w_err != 0) begin
      errors++;
      $display("FAIL midop_track_01_11: got inc=%0d at %0d other=%0d want inc=1 at 7",
               w_inc, t_inc, w_dec + w_err);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_glitch();
    test_illegal();
    test_index();
    test_collision();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
